text_ram_writer: RTL and testbench

Character-stream front end for the 32x32 text RAM feeding the character display. Accepts bytes over a valid/ready handshake, interprets a small set of control codes, tracks a cursor, and issues single-cycle RAM writes only inside a write window supplied by the top level (blanking), so display reads are never disturbed. Sits directly upstream of the `RAM_sync` text buffer; the top level muxes `ram_addr` to this block whenever `ram_we` is high.

---
 rtl/text_pkg.sv | 21 ++
 rtl/text_ram_writer_if.sv | 22 ++
 rtl/text_cursor.sv | 42 ++++
 rtl/text_ram_writer.sv | 118 +++++++++++
 tb/tb_text_ram_writer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants and types for the text RAM writer: control codes, screen geometry, FSM states.
package text_pkg;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam int TEXT_COLS = 32;
    localparam int TEXT_ROWS = 32;
    localparam int COL_W     = $clog2(TEXT_COLS);
    localparam int ROW_W     = $clog2(TEXT_ROWS);
    localparam int ADDR_W    = ROW_W + COL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/text_ram_writer_if.sv
// Character-stream handshake plus the text RAM write port and its write window.
interface text_ram_writer_if;
    import text_pkg::*;

    logic [7:0]        char_data;
    logic              char_valid;
    logic              char_ready;
    logic              wr_window;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;

    modport master (
        input  char_data, char_valid, wr_window,
        output char_ready, ram_addr, ram_din, ram_we
    );

    modport slave (
        output char_data, char_valid, wr_window,
        input  char_ready, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/text_cursor.sv
// Cursor row/col registers; home beats advance beats newline beats CR beats backspace.
module text_cursor
    import text_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             newline,
    input  logic             cr,
    input  logic             backspace,
    input  logic             home,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TEXT_COLS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end else if (newline) begin
            col <= '0;
            row <= row + ROW_W'(1);
        end else if (cr) begin
            col <= '0;
        end else if (backspace && col != '0) begin
            col <= col - COL_W'(1);
        end
    end

endmodule

// File: rtl/text_ram_writer.sv
// Byte stream to text RAM writes, gated by the blanking write window.
// Idle holds char_ready low only for the single cycle after reset release.
module text_ram_writer
    import text_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR      = 8'h00,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    text_ram_writer_if.master   bus,
    output logic                busy,
    output logic [ROW_W-1:0]    cursor_row,
    output logic [COL_W-1:0]    cursor_col
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state;
    logic [7:0]        byte_q;
    logic [ADDR_W-1:0] clr_cnt;

    logic accept;
    logic cur_advance;
    logic cur_newline;
    logic cur_cr;
    logic cur_bs;
    logic cur_home;

    assign accept      = bus.char_valid && bus.char_ready;
    assign cur_newline = accept && (bus.char_data == CH_LF);
    assign cur_cr      = accept && (bus.char_data == CH_CR);
    assign cur_bs      = accept && (bus.char_data == CH_BS);
    assign cur_advance = (state == ST_WRITE) && bus.wr_window;
    assign cur_home    = (state == ST_CLEAR) && bus.wr_window && (clr_cnt == ADDR_LAST);

    text_cursor u_cursor (
        .clk       (clk),
        .reset     (reset),
        .advance   (cur_advance),
        .newline   (cur_newline),
        .cr        (cur_cr),
        .backspace (cur_bs),
        .home      (cur_home),
        .row       (cursor_row),
        .col       (cursor_col)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            byte_q         <= '0;
            clr_cnt        <= '0;
            bus.ram_addr   <= '0;
            bus.ram_din    <= '0;
            bus.ram_we     <= 1'b0;
            bus.char_ready <= 1'b0;
            busy           <= 1'b0;
        end else begin
            bus.ram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // char_ready low in IDLE only happens on the first cycle out of reset
                    if (!bus.char_ready) begin
                        if (CLEAR_ON_RESET) begin
                            state   <= ST_CLEAR;
                            clr_cnt <= '0;
                            busy    <= 1'b1;
                        end else begin
                            bus.char_ready <= 1'b1;
                        end
                    end else if (bus.char_valid) begin
                        case (bus.char_data)
                            CH_LF, CH_CR, CH_BS: ;
                            CH_FF: begin
                                state          <= ST_CLEAR;
                                clr_cnt        <= '0;
                                bus.char_ready <= 1'b0;
                                busy           <= 1'b1;
                            end
                            default: begin
                                byte_q         <= bus.char_data;
                                state          <= ST_WRITE;
                                bus.char_ready <= 1'b0;
                                busy           <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (bus.wr_window) begin
                        bus.ram_addr   <= {cursor_row, cursor_col};
                        bus.ram_din    <= byte_q;
                        bus.ram_we     <= 1'b1;
                        state          <= ST_IDLE;
                        bus.char_ready <= 1'b1;
                        busy           <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (bus.wr_window) begin
                        bus.ram_addr <= clr_cnt;
                        bus.ram_din  <= FILL_CHAR;
                        bus.ram_we   <= 1'b1;
                        clr_cnt      <= clr_cnt + ADDR_W'(1);
                        if (clr_cnt == ADDR_LAST) begin
                            state          <= ST_IDLE;
                            bus.char_ready <= 1'b1;
                            busy           <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_ram_writer.sv
// Directed stimulus with a write scoreboard; expected RAM writes are queued, a monitor pops them.
module tb_text_ram_writer;
    import text_pkg::*;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [4:0] cursor_row;
    logic [4:0] cursor_col;

    text_ram_writer_if bus ();

    text_ram_writer #(.FILL_CHAR(8'h00), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Write monitor: every ram_we pulse must match the head of the scoreboard
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.ram_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected actual=%0h:%0h required=none", bus.ram_addr, bus.ram_din);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.ram_addr, bus.ram_din} !== e) begin
                        errors++;
                        $display("FAIL write_data actual=%0h:%0h required=%0h:%0h",
                                 bus.ram_addr, bus.ram_din, e[17:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic push_wr(input int addr, input logic [7:0] d);
        logic [9:0] a;
        a = 10'(addr);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.char_data  = b;
        bus.char_valid = 1'b1;
        while (bus.char_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_timeout", 32'(n), 0);
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && bus.char_ready === 1'b1) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n >= 1200), 0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(bus.ram_we), 0);
        chk({tag, "_addr"}, 32'(bus.ram_addr), 0);
        chk({tag, "_din"}, 32'(bus.ram_din), 0);
        chk({tag, "_ready"}, 32'(bus.char_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cursor"}, {22'd0, cursor_row, cursor_col}, 0);
    endtask

    initial begin
        int n;
        int seen;
        reset          = 1'b1;
        bus.char_data  = 8'h00;
        bus.char_valid = 1'b0;
        bus.wr_window  = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // Power-up clear: 1024 zero writes in address order
        for (int i = 0; i < 1024; i++) push_wr(i, 8'h00);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("clear_busy", 32'(busy), 1);
        wait_idle("clear_done_timeout");
        chk("clear_ready", 32'(bus.char_ready), 1);
        chk("clear_queue", 32'(exp_q.size()), 0);

        // Two printable bytes
        push_wr(10'h000, 8'h41);
        send(8'h41);
        push_wr(10'h001, 8'h42);
        send(8'h42);
        settle();
        chk("ab_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 5'd0, 5'd2});

        // Fill row 0 up to col 30, then the col-31 write wraps to row 1
        for (int c = 2; c < 31; c++) begin
            push_wr(c, 8'(8'h20 + c));
            send(8'(8'h20 + c));
        end
        settle();
        chk("col30_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 5'd0, 5'd31});
        push_wr(10'h01F, 8'h35);
        send(8'h35);
        settle();
        chk("wrap_col_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 5'd1, 5'd0});

        // Walk to (31,31) and wrap the row with LF
        for (int r = 1; r < 31; r++) send(CH_LF);
        settle();
        chk("lf_row31", {22'd0, cursor_row, cursor_col}, {22'd0, 5'd31, 5'd0});
        for (int c = 0; c < 31; c++) begin
            push_wr(992 + c, 8'h61);
            send(8'h61);
        end
        settle();
        chk("pos_31_31", {22'd0, cursor_row, cursor_col}, {22'd0, 5'd31, 5'd31});
        send(CH_LF);
        settle();
        chk("lf_wrap_home", {22'd0, cursor_row, cursor_col}, 0);

        // Write window closed: byte held in WRITE for 50 cycles
        bus.wr_window = 1'b0;
        send(8'h39);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.char_ready !== 1'b0 || busy !== 1'b1) seen++;
        end
        chk("hold_ready_busy", 32'(seen), 0);
        chk("hold_cursor", {22'd0, cursor_row, cursor_col}, 0);
        push_wr(10'h000, 8'h39);
        bus.wr_window = 1'b1;
        settle();
        chk("window_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 5'd0, 5'd1});
        chk("window_queue", 32'(exp_q.size()), 0);

        // CR / BS: no writes expected
        send(CH_CR);
        settle();
        chk("cr_col", 32'(cursor_col), 0);
        send(CH_BS);
        settle();
        chk("bs_col0", 32'(cursor_col), 0);
        for (int c = 0; c < 5; c++) begin
            push_wr(c, 8'h30);
            send(8'h30);
        end
        settle();
        chk("col5", 32'(cursor_col), 5);
        send(CH_BS);
        settle();
        chk("bs_col5", 32'(cursor_col), 4);
        chk("bs_row", 32'(cursor_row), 0);

        // Reset in the middle of a clear, then the clear restarts from 0
        reset = 1'b0;
        settle();
        for (int i = 0; i <= 300; i++) push_wr(i, 8'h00);
        @(negedge clk) reset = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 1200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midclear_reach_300", 32'(n >= 1200), 0);
        chk("midclear_addr", 32'(bus.ram_addr), 300);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midclear_reset");
        for (int i = 0; i < 1024; i++) push_wr(i, 8'h00);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        wait_idle("reclear_timeout");
        chk("reclear_queue", 32'(exp_q.size()), 0);
        chk("reclear_cursor", {22'd0, cursor_row, cursor_col}, 0);

        repeat (5) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
